atom_lsu: RTL and testbench
===========================

Name: atom_lsu

Overview:
- Parametrised load/store unit for the RV32I core.
- Replaces the current tied-off data-memory port (store enable held at 0, no loads) with a real access path.
- Handles the byte, halfword and word accesses required by LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a single-outstanding strobe/ack data bus, and adds misalignment detection and a bus-timeout error.
- Sits between the core's execute stage and DMEM; the core stalls on ls_busy_o.

Parameters:
- ADDR_WIDTH, 32: width of ls_addr_i and d_addr_o.
- TIMEOUT_CYCLES, 255: maximum number of cycles d_stb_o is held without d_ack_i before the access aborts with an error. 0 disables the timeout.
- ALIGN_CHECK, 1: 1 = misaligned accesses are trapped. 0 = the address low bits are masked and the access proceeds.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ls_req_i  in  1  access request from core, sampled only in IDLE
- ls_we_i  in  1  1 = store, 0 = load
- ls_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- ls_unsigned_i  in  1  zero-extend loads (LBU/LHU)
- ls_addr_i  in  ADDR_WIDTH  byte address
- ls_wdata_i  in  32  store data, right-aligned
- ls_rdata_o  out  32  extended load result, valid while ls_done_o=1
- ls_done_o  out  1  one-cycle completion pulse
- ls_busy_o  out  1  access in flight
- ls_misaligned_o  out  1  qualifies ls_done_o: alignment fault
- ls_err_o  out  1  qualifies ls_done_o: bus timeout
- d_addr_o  out  ADDR_WIDTH  word-aligned bus address, low 2 bits = 0
- d_data_o  out  32  lane-replicated store data
- d_sel_o  out  4  byte-lane enables
- d_we_o  out  1  bus write enable
- d_stb_o  out  1  bus strobe
- d_data_i  in  32  bus read data, sampled with d_ack_i
- d_ack_i  in  1  bus acknowledge

Behaviour:
- Reset: state=IDLE. All outputs 0: ls_rdata_o, ls_done_o, ls_busy_o, ls_misaligned_o, ls_err_o, d_addr_o, d_data_o, d_sel_o, d_we_o, d_stb_o. Timeout counter cleared.
- Reset asserted mid-access: d_stb_o drops asynchronously and no ls_done_o is produced.
- States: IDLE, BUS, FAULT.
- IDLE with ls_req_i=1:
  - Misaligned (ALIGN_CHECK=1 and any of: half with addr[0]=1; word with addr[1:0]!=0; size=11): go to FAULT.
  - Size=11 is always a fault, even with ALIGN_CHECK=0.
  - Otherwise: register d_addr_o, d_sel_o, d_data_o, d_we_o; set d_stb_o=1 and ls_busy_o=1; go to BUS. Byte offset and size are captured for load extraction.
- BUS:
  - d_stb_o and all bus outputs are held stable until ack.
  - On a clock edge with d_ack_i=1: d_stb_o=0, ls_busy_o=0, ls_done_o=1 for one cycle; for loads, ls_rdata_o is registered from d_data_i; go to IDLE.
  - A timeout counter increments each BUS cycle without ack. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES: d_stb_o=0, ls_done_o=1, ls_err_o=1, ls_rdata_o=0; go to IDLE.
  - A late d_ack_i after a timeout is ignored.
- FAULT: lasts one cycle; ls_busy_o=1, no bus activity. Then ls_done_o=1, ls_misaligned_o=1, ls_rdata_o=0; go to IDLE.
- ls_misaligned_o and ls_err_o are 1 only together with ls_done_o, and never simultaneously.
- ls_req_i is ignored in BUS and FAULT; the core holds its request while busy.
- Back-to-back: a request present in the cycle where ls_done_o=1 (state already IDLE) is accepted, so the next d_stb_o rises on the following edge.
- Latency: request at edge N; d_stb_o high from N+1; ack sampled at edge N+1+k; ls_done_o high in cycle N+2+k. A fault gives ls_done_o in cycle N+2.
- Lane rules, with o = addr[1:0]:
  - Byte: d_sel_o = 4'b0001<<o; d_data_o = {4{wdata[7:0]}}.
  - Half: d_sel_o = 4'b0011<<o; d_data_o = {2{wdata[15:0]}}.
  - Word: d_sel_o = 4'b1111; d_data_o = wdata.
  - With ALIGN_CHECK=0, o is masked: half uses {o[1],0}; word uses 00.
- Load extraction: shift d_data_i right by 8*o, then sign- or zero-extend from bit 7 (byte) or bit 15 (half) according to ls_unsigned_i. Word loads are passed through unchanged.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1); the counter is cleared on entry to BUS.

Test Plan:
- LB at addr 0x103, d_data_i=0x80AABBCC, ack one cycle after stb -> d_sel_o=0x0 during fault? no: d_sel_o=4'b1000; ls_rdata_o=0xFFFFFF80 with ls_done_o for one cycle; LBU at the same address -> 0x00000080.
- SH at addr 0x202, wdata=0x1234ABCD -> d_addr_o=0x200, d_sel_o=4'b1100, d_data_o=0xABCDABCD, d_we_o=1, stb held for 3 wait cycles until ack, then done with no error flags.
- LW at addr 0x105 (ALIGN_CHECK=1) -> d_stb_o never asserted; ls_done_o=1 and ls_misaligned_o=1 two cycles after the request; ls_rdata_o=0. Same access with ALIGN_CHECK=0 -> bus read at 0x104, sel 4'b1111.
- TIMEOUT_CYCLES=4, no ack -> d_stb_o high exactly 4 cycles, then ls_done_o=1 with ls_err_o=1. A late ack the next cycle produces no second done.
- Back-to-back SW then LW, both acked in 0 wait states, req held high -> second d_stb_o rises on the cycle after the first ls_done_o; total 4 cycles for two accesses.
- rst_i asserted asynchronously while in BUS -> d_stb_o and ls_busy_o fall before the next clock edge; no ls_done_o after reset release.

Source files
------------

// File: rtl/atom_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : atom_lsu_if
//  Purpose  : Core-side request/response and DMEM strobe/ack bus bundle
//             for the atom load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface atom_lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    // core side
    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [1:0]            ls_size_i;
    logic                  ls_unsigned_i;
    logic [ADDR_WIDTH-1:0] ls_addr_i;
    logic [31:0]           ls_wdata_i;
    logic [31:0]           ls_rdata_o;
    logic                  ls_done_o;
    logic                  ls_busy_o;
    logic                  ls_misaligned_o;
    logic                  ls_err_o;
    // data-memory side
    logic [ADDR_WIDTH-1:0] d_addr_o;
    logic [31:0]           d_data_o;
    logic [3:0]            d_sel_o;
    logic                  d_we_o;
    logic                  d_stb_o;
    logic [31:0]           d_data_i;
    logic                  d_ack_i;

    // the LSU itself
    modport master (
        input  ls_req_i, ls_we_i, ls_size_i, ls_unsigned_i, ls_addr_i, ls_wdata_i,
        input  d_data_i, d_ack_i,
        output ls_rdata_o, ls_done_o, ls_busy_o, ls_misaligned_o, ls_err_o,
        output d_addr_o, d_data_o, d_sel_o, d_we_o, d_stb_o
    );

    // the surrounding core and memory
    modport slave (
        output ls_req_i, ls_we_i, ls_size_i, ls_unsigned_i, ls_addr_i, ls_wdata_i,
        output d_data_i, d_ack_i,
        input  ls_rdata_o, ls_done_o, ls_busy_o, ls_misaligned_o, ls_err_o,
        input  d_addr_o, d_data_o, d_sel_o, d_we_o, d_stb_o
    );
endinterface
`default_nettype wire

// File: rtl/atom_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : atom_lsu
//  Purpose  : RV32I load/store unit. Byte/half/word accesses over a single
//             outstanding strobe/ack bus, with alignment trap and bus timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module atom_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ALIGN_CHECK    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    atom_lsu_if.master bus
);

    // counter is kept at least one bit wide so a disabled timeout still elaborates
    localparam int                  c_CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [31:0]           r_dout, w_dout;
    logic [3:0]            r_sel, w_sel;
    logic                  r_we, w_we;
    logic                  r_stb, w_stb;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_mis, w_mis;
    logic                  r_err, w_err;
    logic [31:0]           r_rdata, w_rdata;
    logic [1:0]            r_off, w_off_q;
    logic [1:0]            r_size, w_size_q;
    logic                  r_uns, w_uns_q;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt;

    logic                  w_fault;
    logic [1:0]            w_off;
    logic [3:0]            w_lane_sel;
    logic [31:0]           w_lane_data;
    logic [31:0]           w_shift;
    logic [31:0]           w_load;

    // request decode: fault detection, effective lane offset, byte enables and replicated store data
    always_comb begin
        w_fault     = (bus.ls_size_i == 2'b11) ||
                      (ALIGN_CHECK && (((bus.ls_size_i == 2'b01) && bus.ls_addr_i[0]) ||
                                       ((bus.ls_size_i == 2'b10) && (bus.ls_addr_i[1:0] != 2'b00))));
        w_off       = 2'b00;
        w_lane_sel  = 4'b1111;
        w_lane_data = bus.ls_wdata_i;
        case (bus.ls_size_i)
            2'b00: begin
                w_off       = bus.ls_addr_i[1:0];
                w_lane_sel  = 4'b0001 << w_off;
                w_lane_data = {4{bus.ls_wdata_i[7:0]}};
            end
            2'b01: begin
                // bit 0 masked: only reachable with a set bit 0 when the trap is disabled
                w_off       = {bus.ls_addr_i[1], 1'b0};
                w_lane_sel  = 4'b0011 << w_off;
                w_lane_data = {2{bus.ls_wdata_i[15:0]}};
            end
            default: begin
                w_off       = 2'b00;
                w_lane_sel  = 4'b1111;
                w_lane_data = bus.ls_wdata_i;
            end
        endcase
    end

    // load extraction: align the addressed lane to bit 0, then sign/zero extend
    always_comb begin
        w_shift = bus.d_data_i >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = bus.d_data_i;
        endcase
    end

    // next-state and next-output logic; completion flags default to a single-cycle pulse
    always_comb begin
        w_state  = r_state;
        w_addr   = r_addr;
        w_dout   = r_dout;
        w_sel    = r_sel;
        w_we     = r_we;
        w_stb    = r_stb;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_mis    = 1'b0;
        w_err    = 1'b0;
        w_rdata  = 32'd0;
        w_off_q  = r_off;
        w_size_q = r_size;
        w_uns_q  = r_uns;
        w_cnt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.ls_req_i) begin
                    w_busy = 1'b1;
                    if (w_fault) begin
                        w_state = S_FAULT;
                    end else begin
                        w_addr   = {bus.ls_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        w_dout   = w_lane_data;
                        w_sel    = w_lane_sel;
                        w_we     = bus.ls_we_i;
                        w_stb    = 1'b1;
                        w_off_q  = w_off;
                        w_size_q = bus.ls_size_i;
                        w_uns_q  = bus.ls_unsigned_i;
                        w_cnt    = '0;
                        w_state  = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // an ack on the final allowed cycle still wins over the timeout
                if (bus.d_ack_i) begin
                    w_stb   = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_rdata = r_we ? 32'd0 : w_load;
                    w_state = S_IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (r_cnt == c_CNT_LAST)) begin
                    w_stb   = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else if (TIMEOUT_CYCLES > 0) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_mis   = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_stb   = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    // state and output registers; reset drops the strobe immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_dout  <= 32'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_off   <= 2'd0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_dout  <= w_dout;
            r_sel   <= w_sel;
            r_we    <= w_we;
            r_stb   <= w_stb;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_mis   <= w_mis;
            r_err   <= w_err;
            r_rdata <= w_rdata;
            r_off   <= w_off_q;
            r_size  <= w_size_q;
            r_uns   <= w_uns_q;
            r_cnt   <= w_cnt;
        end
    end

    assign bus.ls_rdata_o      = r_rdata;
    assign bus.ls_done_o       = r_done;
    assign bus.ls_busy_o       = r_busy;
    assign bus.ls_misaligned_o = r_mis;
    assign bus.ls_err_o        = r_err;
    assign bus.d_addr_o        = r_addr;
    assign bus.d_data_o        = r_dout;
    assign bus.d_sel_o         = r_sel;
    assign bus.d_we_o          = r_we;
    assign bus.d_stb_o         = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_atom_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atom_lsu
//  Purpose  : Directed bench for atom_lsu. Unit A traps misalignment with a
//             4-cycle timeout; unit B masks misalignment, has no timeout and
//             is acked by an always-ready responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_atom_lsu;

    logic        clk;
    logic        rst;
    logic        req, we, uns, ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, bus_data;

    int total = 0;
    int bad   = 0;

    atom_lsu_if #(.ADDR_WIDTH(32)) ifa ();
    atom_lsu_if #(.ADDR_WIDTH(32)) ifb ();

    assign ifa.ls_req_i      = req;
    assign ifa.ls_we_i       = we;
    assign ifa.ls_size_i     = size;
    assign ifa.ls_unsigned_i = uns;
    assign ifa.ls_addr_i     = addr;
    assign ifa.ls_wdata_i    = wdata;
    assign ifa.d_data_i      = bus_data;
    assign ifa.d_ack_i       = ack;

    assign ifb.ls_req_i      = req;
    assign ifb.ls_we_i       = we;
    assign ifb.ls_size_i     = size;
    assign ifb.ls_unsigned_i = uns;
    assign ifb.ls_addr_i     = addr;
    assign ifb.ls_wdata_i    = wdata;
    assign ifb.d_data_i      = 32'h5A5AC3C3;
    assign ifb.d_ack_i       = ifb.d_stb_o;

    atom_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .ALIGN_CHECK(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa.master)
    );

    atom_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0), .ALIGN_CHECK(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bdata;
        int          waits;
        logic        fault;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_data;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one access on unit A; entered and left 1 time unit after a rising edge
    task automatic run_vec(input vec_t v);
        req = 1'b1; we = v.we; size = v.size; uns = v.uns;
        addr = v.addr; wdata = v.wdata; bus_data = v.bdata; ack = 1'b0;
        step();
        req = 1'b0;
        if (v.fault) begin
            chk("fault_no_stb", 32'(ifa.d_stb_o), 32'd0);
            chk("fault_busy",   32'(ifa.ls_busy_o), 32'd1);
            step();
            chk("fault_done",   32'(ifa.ls_done_o), 32'd1);
            chk("fault_mis",    32'(ifa.ls_misaligned_o), 32'd1);
            chk("fault_err",    32'(ifa.ls_err_o), 32'd0);
            chk("fault_rdata",  ifa.ls_rdata_o, 32'd0);
            chk("fault_stb",    32'(ifa.d_stb_o), 32'd0);
        end else begin
            chk("bus_stb",  32'(ifa.d_stb_o), 32'd1);
            chk("bus_busy", 32'(ifa.ls_busy_o), 32'd1);
            chk("bus_addr", ifa.d_addr_o, v.e_addr);
            chk("bus_sel",  32'(ifa.d_sel_o), 32'(v.e_sel));
            chk("bus_data", ifa.d_data_o, v.e_data);
            chk("bus_we",   32'(ifa.d_we_o), 32'(v.we));
            for (int w = 0; w < v.waits; w++) begin
                step();
                chk("hold_stb",  32'(ifa.d_stb_o), 32'd1);
                chk("hold_sel",  32'(ifa.d_sel_o), 32'(v.e_sel));
                chk("hold_addr", ifa.d_addr_o, v.e_addr);
                chk("hold_done", 32'(ifa.ls_done_o), 32'd0);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("ack_done", 32'(ifa.ls_done_o), 32'd1);
            chk("ack_err",  32'(ifa.ls_err_o), 32'd0);
            chk("ack_mis",  32'(ifa.ls_misaligned_o), 32'd0);
            chk("ack_stb",  32'(ifa.d_stb_o), 32'd0);
            chk("ack_busy", 32'(ifa.ls_busy_o), 32'd0);
            if (!v.we) chk("load_rdata", ifa.ls_rdata_o, v.e_rdata);
        end
        step();
        chk("done_one_cycle", 32'(ifa.ls_done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ncyc;
        int ndone;

        //           we    size   uns   addr        wdata         bdata         w  flt   e_addr      e_sel    e_data        e_rdata
        vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h103,  32'h0,        32'h80AABBCC, 0, 1'b0, 32'h100,  4'b1000, 32'h0,        32'hFFFFFF80};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h103,  32'h0,        32'h80AABBCC, 1, 1'b0, 32'h100,  4'b1000, 32'h0,        32'h00000080};
        vt[2]  = '{1'b1, 2'b01, 1'b0, 32'h202,  32'h1234ABCD, 32'h0,        3, 1'b0, 32'h200,  4'b1100, 32'hABCDABCD, 32'h0};
        vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h105,  32'h0,        32'h0,        0, 1'b1, 32'h0,    4'b0000, 32'h0,        32'h0};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h102,  32'h0,        32'h80AABBCC, 0, 1'b0, 32'h100,  4'b1100, 32'h0,        32'hFFFF80AA};
        vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h100,  32'h0,        32'h80AABBCC, 2, 1'b0, 32'h100,  4'b0011, 32'h0,        32'h0000BBCC};
        vt[6]  = '{1'b0, 2'b00, 1'b0, 32'h101,  32'h0,        32'h80AABBCC, 0, 1'b0, 32'h100,  4'b0010, 32'h0,        32'hFFFFFFBB};
        vt[7]  = '{1'b1, 2'b00, 1'b0, 32'h2003, 32'h000000A5, 32'h0,        0, 1'b0, 32'h2000, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vt[8]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1, 1'b0, 32'h10,   4'b1111, 32'hDEADBEEF, 32'h0};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h12345678, 0, 1'b0, 32'h20,   4'b1111, 32'h0,        32'h12345678};
        vt[10] = '{1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0,        0, 1'b1, 32'h0,    4'b0000, 32'h0,        32'h0};
        vt[11] = '{1'b0, 2'b01, 1'b0, 32'h101,  32'h0,        32'h0,        0, 1'b1, 32'h0,    4'b0000, 32'h0,        32'h0};
        vt[12] = '{1'b1, 2'b01, 1'b0, 32'h201,  32'h1111,     32'h0,        0, 1'b1, 32'h0,    4'b0000, 32'h0,        32'h0};
        vt[13] = '{1'b0, 2'b00, 1'b0, 32'h102,  32'h0,        32'h007F8000, 0, 1'b0, 32'h100,  4'b0100, 32'h0,        32'h0000007F};
        vt[14] = '{1'b1, 2'b01, 1'b0, 32'h300,  32'hFFFF5AA5, 32'h0,        0, 1'b0, 32'h300,  4'b0011, 32'h5AA55AA5, 32'h0};

        rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0; ack = 1'b0;
        size = 2'b00; addr = 32'h0; wdata = 32'h0; bus_data = 32'h0;

        // reset state
        repeat (2) step();
        chk("rst_rdata", ifa.ls_rdata_o, 32'd0);
        chk("rst_done",  32'(ifa.ls_done_o), 32'd0);
        chk("rst_busy",  32'(ifa.ls_busy_o), 32'd0);
        chk("rst_mis",   32'(ifa.ls_misaligned_o), 32'd0);
        chk("rst_err",   32'(ifa.ls_err_o), 32'd0);
        chk("rst_addr",  ifa.d_addr_o, 32'd0);
        chk("rst_data",  ifa.d_data_o, 32'd0);
        chk("rst_sel",   32'(ifa.d_sel_o), 32'd0);
        chk("rst_we",    32'(ifa.d_we_o), 32'd0);
        chk("rst_stb",   32'(ifa.d_stb_o), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_stb", 32'(ifa.d_stb_o), 32'd0);

        // table vectors
        for (int i = 0; i < 15; i++) run_vec(vt[i]);

        // masking unit: misaligned word goes to the bus on the aligned word
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h105; wdata = 32'h0;
        step();
        req = 1'b0;
        chk("mask_stb",   32'(ifb.d_stb_o), 32'd1);
        chk("mask_addr",  ifb.d_addr_o, 32'h104);
        chk("mask_sel",   32'(ifb.d_sel_o), 32'hF);
        chk("trap_nostb", 32'(ifa.d_stb_o), 32'd0);
        step();
        chk("mask_done",  32'(ifb.ls_done_o), 32'd1);
        chk("mask_rdata", ifb.ls_rdata_o, 32'h5A5AC3C3);
        chk("mask_mis",   32'(ifb.ls_misaligned_o), 32'd0);
        chk("trap_done",  32'(ifa.ls_done_o), 32'd1);
        chk("trap_mis",   32'(ifa.ls_misaligned_o), 32'd1);
        step();

        // masking unit: illegal size still faults
        req = 1'b1; size = 2'b11; addr = 32'h8;
        step();
        req = 1'b0;
        chk("mask_sz3_nostb", 32'(ifb.d_stb_o), 32'd0);
        step();
        chk("mask_sz3_done", 32'(ifb.ls_done_o), 32'd1);
        chk("mask_sz3_mis",  32'(ifb.ls_misaligned_o), 32'd1);
        step();

        // half store with masked offset on the masking unit
        req = 1'b1; we = 1'b1; size = 2'b01; addr = 32'h203; wdata = 32'h0000BEEF;
        step();
        req = 1'b0;
        chk("mask_half_sel",  32'(ifb.d_sel_o), 32'hC);
        chk("mask_half_data", ifb.d_data_o, 32'hBEEFBEEF);
        repeat (2) step();

        // timeout: no ack, strobe lasts exactly 4 cycles
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40; ack = 1'b0;
        step();
        req = 1'b0;
        ncyc = 0;
        while (ifa.d_stb_o && ncyc < 10) begin
            ncyc++;
            step();
        end
        chk("to_stb_cycles", 32'(ncyc), 32'd4);
        chk("to_done",  32'(ifa.ls_done_o), 32'd1);
        chk("to_err",   32'(ifa.ls_err_o), 32'd1);
        chk("to_mis",   32'(ifa.ls_misaligned_o), 32'd0);
        chk("to_rdata", ifa.ls_rdata_o, 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("late_ack_done", 32'(ifa.ls_done_o), 32'd0);
        chk("late_ack_stb",  32'(ifa.d_stb_o), 32'd0);
        step();
        chk("late_ack_done2", 32'(ifa.ls_done_o), 32'd0);

        // back-to-back SW then LW, zero wait states, request held
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h11223344;
        ack = 1'b1; bus_data = 32'hCAFEF00D;
        step();
        chk("b2b_stb1",  32'(ifa.d_stb_o), 32'd1);
        chk("b2b_we1",   32'(ifa.d_we_o), 32'd1);
        step();
        chk("b2b_done1", 32'(ifa.ls_done_o), 32'd1);
        we = 1'b0;
        step();
        chk("b2b_stb2",  32'(ifa.d_stb_o), 32'd1);
        chk("b2b_we2",   32'(ifa.d_we_o), 32'd0);
        chk("b2b_gap",   32'(ifa.ls_done_o), 32'd0);
        step();
        req = 1'b0;
        chk("b2b_done2", 32'(ifa.ls_done_o), 32'd1);
        chk("b2b_rdata", ifa.ls_rdata_o, 32'hCAFEF00D);
        ack = 1'b0;
        repeat (2) step();

        // asynchronous reset in the middle of a bus access
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h80; ack = 1'b0;
        step();
        req = 1'b0;
        chk("ar_stb_before", 32'(ifa.d_stb_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_stb_drop",  32'(ifa.d_stb_o), 32'd0);
        chk("ar_busy_drop", 32'(ifa.ls_busy_o), 32'd0);
        #2 rst = 1'b0;
        ack = 1'b1;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ifa.ls_done_o) ndone++;
        end
        ack = 1'b0;
        chk("ar_no_done", 32'(ndone), 32'd0);
        chk("ar_stb_idle", 32'(ifa.d_stb_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
